div_32_bit_seq: RTL

Multi-cycle 32-bit unsigned restoring divider: the inverse arithmetic path to the 32-bit adder, reusing it in subtract mode (a + ~b + 1) for one trial subtraction per cycle. Sits beside the ALU as a long-latency functional unit. The start/done handshake produces one quotient bit per clock, so a result arrives 33 cycles after issue.

---
 rtl/div_32_bit_seq_pkg.sv | 14 +
 rtl/adder_32_bit.sv | 15 +
 rtl/div_32_bit_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_32_bit_seq_pkg.sv
// Shared definitions for the sequential 32-bit restoring divider.
package div_32_bit_seq_pkg;

    // Divider control states; encodings are fixed and shared with other units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // One quotient bit is produced per iteration.
    localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit ripple-style adder with carry in/out; used by the divider in subtract mode.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    // Full-width add; the carry out doubles as the no-borrow flag when b is inverted.
    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
    end

endmodule

// File: rtl/div_32_bit_seq.sv
// Multi-cycle 32-bit unsigned restoring divider, one quotient bit per clock.
module div_32_bit_seq
    import div_32_bit_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    div_state_t  state;
    div_state_t  state_next;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic [31:0] d_reg;
    logic [5:0]  count;

    logic [31:0] shifted;
    logic [31:0] diff;
    logic        c_out;
    logic        ge;
    logic        last_iter;
    logic [31:0] r_iter;
    logic [31:0] q_iter;

    // Trial subtraction S - D computed as S + ~D + 1.
    assign shifted = {r_reg[30:0], q_reg[31]};

    adder_32_bit u_sub (
        .a     (shifted),
        .b     (~d_reg),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (c_out)
    );

    // One restoring step; R[31] set means the 33-bit shifted value exceeds any divisor.
    always_comb begin
        ge        = r_reg[31] | c_out;
        r_iter    = ge ? diff : shifted;
        q_iter    = {q_reg[30:0], ge};
        last_iter = (count == 6'(DIV_ITERS - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and held results; results only move on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q_reg <= dividend;
                            r_reg <= '0;
                            d_reg <= divisor;
                            count <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_iter;
                    r_reg <= r_iter;
                    count <= count + 6'd1;
                    if (last_iter) begin
                        quotient    <= q_iter;
                        remainder   <= r_iter;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
